// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART serial data path.
//  - State encoding localparams and the serializer state enum (IDLE / SHIFT).
//  - cnt_width(): width of a bit counter covering 0..n-1, never narrower than 1 bit.
//  - DEFAULT_IDLE_LEVEL: line level driven while no word is being shifted.
// No ports (package).
package uart_pkg;

  localparam logic ST_IDLE_ENC  = 1'b0;
  localparam logic ST_SHIFT_ENC = 1'b1;

  typedef enum logic {
    ST_IDLE  = ST_IDLE_ENC,
    ST_SHIFT = ST_SHIFT_ENC
  } ser_state_e;

  localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage : uart_pkg

// File: rtl/ser_bit_cnt.sv
// ser_bit_cnt: bit-period counter shared by the serializer and deserializer.
// Counts enabled ticks from 0 to N-1 and wraps back to 0 on the tick that
// ends the last bit, so the count never leaves the 0..N-1 range.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (count -> 0)
//   clr   in   force count to 0 (wins over en)
//   en    in   one bit period ended; advance or wrap
//   cnt   out  current bit index, CW = max(1, clog2(N)) bits
//   last  out  1 while cnt == N-1 (the final bit of the word)
module ser_bit_cnt
  import uart_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  localparam logic [CW-1:0] LAST_VAL = CW'(N - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  assign last = (cnt_q == LAST_VAL);
  assign cnt  = cnt_q;

  always_comb begin
    // NOTE: the default is assigned before any branch so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : ser_bit_cnt

// File: rtl/param_serializer.sv
// param_serializer: parallel-to-serial shifter for the UART TX data path.
// Takes a DATA_WIDTH word on a valid/ready handshake and drives it out one bit
// per baud tick, LSB- or MSB-first, with a one-cycle done pulse after the last
// bit period. Framing (start/stop/parity) is added elsewhere.
//
// Optional feature: define PARAM_SERIALIZER_HOLD_EN to add a one-word holding
// register, so a new word can be taken while one is shifting and the two go
// out with no idle bit between them. Without it, Ready is only high in IDLE.
//
// Ports:
//   ParSer_CLK         in   clock, rising edge
//   ParSer_RST_SYN     in   synchronous active-high reset
//   ParSer_Tick        in   baud enable, one pulse per bit period
//   ParSer_Data        in   parallel word, sampled on accept
//   ParSer_Valid       in   word offered
//   ParSer_Ready       out  word can be taken (accept = Valid & Ready)
//   ParSer_SerialData  out  registered serial line
//   ParSer_Busy        out  high while a word is shifting
//   ParSer_Done        out  one-cycle pulse after the last bit period
module param_serializer
  import uart_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   MSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic                  ParSer_CLK,
  input  logic                  ParSer_RST_SYN,
  input  logic                  ParSer_Tick,
  input  logic [DATA_WIDTH-1:0] ParSer_Data,
  input  logic                  ParSer_Valid,
  output logic                  ParSer_Ready,
  output logic                  ParSer_SerialData,
  output logic                  ParSer_Busy,
  output logic                  ParSer_Done
);

  localparam int CW = cnt_width(DATA_WIDTH);

  ser_state_e            state_d, state_q;
  logic [DATA_WIDTH-1:0] word_d, word_q;
  logic                  serial_d, serial_q;
  logic                  done_d, done_q;
`ifdef PARAM_SERIALIZER_HOLD_EN
  logic [DATA_WIDTH-1:0] hold_d, hold_q;
  logic                  hold_full_d, hold_full_q;
`endif

  logic          cnt_clr, cnt_en, bit_last;
  logic [CW-1:0] bit_cnt, next_idx;
  logic          accept;

  // Bit idx of a word in transmit order; idx 0 is the first bit on the line.
  function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] w,
                                    input logic [CW-1:0]         idx);
    logic [DATA_WIDTH-1:0] tmp;
    if (MSB_FIRST != 0) begin
      tmp = w << idx;
      return tmp[DATA_WIDTH-1];
    end
    tmp = w >> idx;
    return tmp[0];
  endfunction

  ser_bit_cnt #(
    .N (DATA_WIDTH)
  ) u_bit_cnt (
    .clk  (ParSer_CLK),
    .rst  (ParSer_RST_SYN),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (bit_cnt),
    .last (bit_last)
  );

  // Ready is held low during reset so nothing looks accepted while state is being dropped.
`ifdef PARAM_SERIALIZER_HOLD_EN
  assign ParSer_Ready = ~ParSer_RST_SYN & ~hold_full_q;
`else
  assign ParSer_Ready = ~ParSer_RST_SYN & (state_q == ST_IDLE);
`endif

  assign accept   = ParSer_Valid & ParSer_Ready;
  assign next_idx = bit_cnt + CW'(1);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
`ifdef PARAM_SERIALIZER_HOLD_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // A tick on the accept edge is ignored: the counter starts cleared.
        if (accept) begin
          word_d   = ParSer_Data;
          serial_d = pick_bit(ParSer_Data, '0);
          state_d  = ST_SHIFT;
          cnt_clr  = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (ParSer_Tick) begin
          cnt_en = 1'b1;  // the counter wraps to 0 by itself on the last bit
          if (!bit_last) begin
            serial_d = pick_bit(word_q, next_idx);
          end else begin
            done_d = 1'b1;
`ifdef PARAM_SERIALIZER_HOLD_EN
            if (hold_full_q) begin
              word_d      = hold_q;
              serial_d    = pick_bit(hold_q, '0);
              hold_full_d = 1'b0;
            end else if (accept) begin
              word_d   = ParSer_Data;
              serial_d = pick_bit(ParSer_Data, '0);
            end else begin
              serial_d = IDLE_LEVEL;
              state_d  = ST_IDLE;
            end
`else
            serial_d = IDLE_LEVEL;
            state_d  = ST_IDLE;
`endif
          end
        end
`ifdef PARAM_SERIALIZER_HOLD_EN
        // An accept on the final tick went straight to the shift register above.
        if (accept && !(ParSer_Tick && bit_last)) begin
          hold_d      = ParSer_Data;
          hold_full_d = 1'b1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge ParSer_CLK) begin
    if (ParSer_RST_SYN) begin
      state_q     <= ST_IDLE;
      serial_q    <= IDLE_LEVEL;
      done_q      <= 1'b0;
`ifdef PARAM_SERIALIZER_HOLD_EN
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
`ifdef PARAM_SERIALIZER_HOLD_EN
      hold_full_q <= hold_full_d;
`endif
    end
  end

  // NOTE: word storage carries no reset; it is only read after a load, and the control flops above gate that.
  always_ff @(posedge ParSer_CLK) begin
    word_q <= word_d;
`ifdef PARAM_SERIALIZER_HOLD_EN
    hold_q <= hold_d;
`endif
  end

  assign ParSer_SerialData = serial_q;
  assign ParSer_Busy       = (state_q == ST_SHIFT);
  assign ParSer_Done       = done_q;

endmodule : param_serializer

// File: tb/tb_param_serializer.sv
// Self-checking bench for param_serializer.
// Main instance (8 bits, LSB first) is compared every cycle against a
// queue-based behavioural model; 5-bit MSB-first and 1-bit instances are
// checked against hand-computed line sequences.
module tb_param_serializer;

`ifdef PARAM_SERIALIZER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit LSB-first instance
  logic       tick8, valid8, ready8, line8, busy8, done8;
  logic [7:0] data8;
  // 5-bit MSB-first instance
  logic       tick5, valid5, ready5, line5, busy5, done5;
  logic [4:0] data5;
  // 1-bit instance
  logic       tick1, valid1, ready1, line1, busy1, done1;
  logic [0:0] data1;

  param_serializer #(.DATA_WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) u8 (
    .ParSer_CLK(clk), .ParSer_RST_SYN(rst), .ParSer_Tick(tick8),
    .ParSer_Data(data8), .ParSer_Valid(valid8), .ParSer_Ready(ready8),
    .ParSer_SerialData(line8), .ParSer_Busy(busy8), .ParSer_Done(done8));

  param_serializer #(.DATA_WIDTH(5), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) u5 (
    .ParSer_CLK(clk), .ParSer_RST_SYN(rst), .ParSer_Tick(tick5),
    .ParSer_Data(data5), .ParSer_Valid(valid5), .ParSer_Ready(ready5),
    .ParSer_SerialData(line5), .ParSer_Busy(busy5), .ParSer_Done(done5));

  param_serializer #(.DATA_WIDTH(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b1)) u1 (
    .ParSer_CLK(clk), .ParSer_RST_SYN(rst), .ParSer_Tick(tick1),
    .ParSer_Data(data1), .ParSer_Valid(valid1), .ParSer_Ready(ready1),
    .ParSer_SerialData(line1), .ParSer_Busy(busy1), .ParSer_Done(done1));

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- behavioural model of the 8-bit instance ----------------
  // The word in flight is a queue of bits still to be sent after the one on the line.
  bit         m_q[$];
  logic       m_line = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_hold_full = 1'b0;
  logic [7:0] m_hold = '0;

  function automatic logic m_ready();
    return !rst && (HOLD ? !m_hold_full : !m_busy);
  endfunction

  task automatic m_start(input logic [7:0] w);
    m_q.delete();
    for (int i = 0; i < 8; i++) m_q.push_back(w[i]);
    m_line = m_q.pop_front();
    m_busy = 1'b1;
  endtask

  always @(posedge clk) begin : model
    logic acc, consumed, was_busy;
    if (rst) begin
      m_q.delete();
      m_line = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_hold_full = 1'b0;
    end else begin
      acc      = valid8 && m_ready();
      consumed = 1'b0;
      was_busy = m_busy;
      m_done   = 1'b0;
      if (was_busy && tick8) begin
        if (m_q.size() > 0) begin
          m_line = m_q.pop_front();
        end else begin
          m_done = 1'b1;
          if (m_hold_full) begin
            m_start(m_hold);
            m_hold_full = 1'b0;
          end else if (HOLD && acc) begin
            m_start(data8);
            consumed = 1'b1;
          end else begin
            m_busy = 1'b0;
            m_line = 1'b1;
          end
        end
      end
      if (acc && !consumed) begin
        if (!was_busy) m_start(data8);
        else begin
          m_hold = data8;
          m_hold_full = 1'b1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Advance one clock and compare the 8-bit instance against the model.
  task automatic step();
    @(posedge clk);
    #1;
    check1("cmp_line",  line8,  m_line);
    check1("cmp_busy",  busy8,  m_busy);
    check1("cmp_done",  done8,  m_done);
    check1("cmp_ready", ready8, m_ready());
  endtask

  logic t1_line [8]  = '{0, 1, 1, 0, 1, 0, 1, 1};              // 8'hD6, LSB first
  logic t2_line [5]  = '{1, 0, 0, 1, 1};                       // 5'b10011, MSB first
  logic t4_line [8]  = '{0, 0, 1, 1, 1, 1, 0, 0};              // 8'h3C, LSB first
  logic t5_line [16] = '{1, 0, 1, 0, 1, 0, 1, 0,
                         0, 0, 0, 0, 1, 1, 1, 1};              // 8'h55 then 8'hF0

  initial begin
    bit got;
    int idle_cycles, done_pulses;
    logic idle_now, acc;

    rst = 1'b1;
    tick8 = 0; valid8 = 0; data8 = '0;
    tick5 = 0; valid5 = 0; data5 = '0;
    tick1 = 0; valid1 = 0; data1 = '0;
    step();
    step();
    check1("rst_line", line8, 1'b1);
    check1("rst_busy", busy8, 1'b0);
    check1("rst_done", done8, 1'b0);
    rst = 1'b0;
    #1;
    check1("rst_ready_after_release", ready8, 1'b1);

    // ---- 1: 8'hD6, LSB first, tick every 4 cycles ----
    valid8 = 1; data8 = 8'hD6;
    step();
    valid8 = 0; data8 = 8'h00;
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 4; j++) begin
        check1("t1_line", line8, t1_line[b]);
        check1("t1_busy", busy8, 1'b1);
        tick8 = (j == 3);
        step();
      end
    end
    tick8 = 0;
    check1("t1_done", done8, 1'b1);
    check1("t1_idle_line", line8, 1'b1);
    check1("t1_busy_low", busy8, 1'b0);
    step();
    check1("t1_done_one_cycle", done8, 1'b0);

    // ---- 2: 5-bit MSB first, 5'b10011, tick every 2 cycles ----
    valid5 = 1; data5 = 5'b10011;
    step();
    valid5 = 0;
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 2; j++) begin
        check1("t2_line", line5, t2_line[b]);
        check1("t2_busy", busy5, 1'b1);
        tick5 = (j == 1);
        step();
      end
    end
    tick5 = 0;
    check1("t2_done", done5, 1'b1);
    check1("t2_idle_line", line5, 1'b1);
    check1("t2_busy_low", busy5, 1'b0);
    step();
    check1("t2_done_one_cycle", done5, 1'b0);

`ifndef PARAM_SERIALIZER_HOLD_EN
    // ---- 3: Valid pulse mid-word refused; held Valid taken after Busy falls ----
    valid8 = 1; data8 = 8'h9A;
    step();
    valid8 = 0;
    got = 0; idle_cycles = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      tick8 = (c % 3 == 2);
      if (c == 5) begin
        valid8 = 1; data8 = 8'h77;
        check1("t3_ready_mid_word", ready8, 1'b0);
      end else if (c == 6) begin
        valid8 = 0;
      end
      if (c >= 10) begin
        valid8 = 1; data8 = 8'hC3;
      end
      idle_now = !busy8;
      if (idle_now) idle_cycles++;
      step();
      if (idle_now && c >= 10) begin
        check1("t3_busy_after_accept", busy8, 1'b1);
        check1("t3_first_bit", line8, 1'b1);
        got = 1;
      end
    end
    check("t3_accepted_within_budget", {31'b0, got}, 1);
    check("t3_idle_gap_cycles", idle_cycles, 1);
    valid8 = 0;
    for (int c = 0; c < 30; c++) begin
      tick8 = (c % 3 == 2);
      step();
    end
    tick8 = 0;
    check1("t3_back_idle", busy8, 1'b0);
`endif

    // ---- 4: reset at bit 3 of 8'hA5, then 8'h3C from bit 0 ----
    valid8 = 1; data8 = 8'hA5;
    step();
    valid8 = 0;
    for (int c = 0; c < 6; c++) begin
      tick8 = (c % 2 == 1);
      step();
    end
    tick8 = 0;
    check1("t4_line_bit3", line8, 1'b0);
    rst = 1;
    step();
    check1("t4_rst_line", line8, 1'b1);
    check1("t4_rst_busy", busy8, 1'b0);
    check1("t4_rst_done", done8, 1'b0);
    rst = 0;
    #1;
    check1("t4_ready", ready8, 1'b1);
    valid8 = 1; data8 = 8'h3C;
    step();
    valid8 = 0;
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 2; j++) begin
        check1("t4_line", line8, t4_line[b]);
        tick8 = (j == 1);
        step();
      end
    end
    tick8 = 0;
    check1("t4_done", done8, 1'b1);

`ifdef PARAM_SERIALIZER_HOLD_EN
    // ---- 5: back-to-back 8'h55, 8'hF0 with no idle bit ----
    step();
    valid8 = 1; data8 = 8'h55;
    step();
    data8 = 8'hF0;
    step();
    valid8 = 0;
    done_pulses = 0;
    for (int b = 0; b < 16; b++) begin
      for (int j = 0; j < 2; j++) begin
        check1("t5_line", line8, t5_line[b]);
        check1("t5_busy", busy8, 1'b1);
        if (done8) done_pulses++;
        tick8 = (j == 1);
        step();
      end
    end
    tick8 = 0;
    check("t5_first_done_pulses", done_pulses, 1);
    check1("t5_second_done", done8, 1'b1);
    check1("t5_idle_line", line8, 1'b1);
    check1("t5_busy_low", busy8, 1'b0);
`endif

    // ---- 6: 1-bit word, tick every cycle ----
    valid1 = 1; data1 = 1'b0; tick1 = 1;
    step();
    valid1 = 0;
    check1("t6_line", line1, 1'b0);
    check1("t6_busy", busy1, 1'b1);
    check1("t6_done_early", done1, 1'b0);
    step();
    check1("t6_done", done1, 1'b1);
    check1("t6_idle_line", line1, 1'b1);
    check1("t6_busy_low", busy1, 1'b0);
    tick1 = 0;
    step();
    check1("t6_done_one_cycle", done1, 1'b0);

    // ---- randomized traffic on the 8-bit instance ----
    valid8 = 0; tick8 = 0;
    for (int c = 0; c < 4000; c++) begin
      rst   = ($urandom_range(0, 499) == 0);
      tick8 = ($urandom_range(0, 3) == 0);
      if (!valid8 && $urandom_range(0, 2) == 0) begin
        valid8 = 1;
        data8  = 8'($urandom);
      end
      acc = valid8 && m_ready();
      step();
      if (acc) begin
        valid8 = ($urandom_range(0, 1) == 0);
        data8  = 8'($urandom);
      end
    end
    rst = 0; valid8 = 0; tick8 = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_param_serializer
